// File: rtl/id_stage.sv
// RiSC-16 instruction-decode stage: cracks the fetched instruction, drives the
// register-file read addresses and holds the ID/EX pipeline register.
module id_stage #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_REG_ADDR_LEN = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [p_WORD_LEN-1:0]     i_instr,
  input  logic [p_WORD_LEN-1:0]     i_pc,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic                      i_hold,
  output logic [p_REG_ADDR_LEN-1:0] o_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_src2,
  output logic                      o_stall,
  output logic                      o_valid,
  output logic [2:0]                o_opcode,
  output logic [p_REG_ADDR_LEN-1:0] o_tgt,
  output logic                      o_wr_en,
  output logic [p_WORD_LEN-1:0]     o_imm,
  output logic [p_WORD_LEN-1:0]     o_pc,
  output logic [p_REG_ADDR_LEN-1:0] o_src1_q,
  output logic [p_REG_ADDR_LEN-1:0] o_src2_q
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  logic [2:0]                op;
  logic [p_REG_ADDR_LEN-1:0] ra, rb, rc;
  logic [p_WORD_LEN-1:0]     imm_s7, imm_lui;

  logic [p_REG_ADDR_LEN-1:0] dec_src1, dec_src2, dec_tgt;
  logic                      dec_wr_en;
  logic [p_WORD_LEN-1:0]     dec_imm;
  logic                      load_use;

  assign op      = i_instr[15:13];
  assign ra      = i_instr[12:10];
  assign rb      = i_instr[9:7];
  assign rc      = i_instr[2:0];
  assign imm_s7  = {{(p_WORD_LEN-7){i_instr[6]}}, i_instr[6:0]};
  assign imm_lui = {i_instr[9:0], {(p_WORD_LEN-10){1'b0}}};

  always_comb begin
    dec_src1  = '0;
    dec_src2  = '0;
    dec_tgt   = '0;
    dec_wr_en = 1'b0;
    dec_imm   = '0;
    unique case (op)
      OP_ADD, OP_NAND: begin
        dec_src1 = rb; dec_src2 = rc; dec_tgt = ra; dec_wr_en = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        dec_src1 = rb; dec_tgt = ra; dec_wr_en = 1'b1; dec_imm = imm_s7;
      end
      OP_LUI: begin
        dec_tgt = ra; dec_wr_en = 1'b1; dec_imm = imm_lui;
      end
      OP_SW: begin
        dec_src1 = rb; dec_src2 = ra; dec_imm = imm_s7;
      end
      OP_BEQ: begin
        dec_src1 = ra; dec_src2 = rb; dec_imm = imm_s7;
      end
      OP_JALR: begin
        dec_src1 = rb; dec_tgt = ra; dec_wr_en = 1'b1;
      end
      default: ;
    endcase
    // r0 is hardwired, so writes to it are dropped at decode
    if (dec_tgt == '0) dec_wr_en = 1'b0;
    if (!i_valid) begin
      dec_src1  = '0;
      dec_src2  = '0;
      dec_wr_en = 1'b0;
    end
  end

  // Source 0 can never match because o_tgt is required to be non-zero.
  assign load_use = o_valid && (o_opcode == OP_LW) && (o_tgt != '0) && i_valid &&
                    ((dec_src1 == o_tgt) || (dec_src2 == o_tgt));

  assign o_stall = (load_use | i_hold) & ~i_flush;
  assign o_src1  = i_hold ? o_src1_q : dec_src1;
  assign o_src2  = i_hold ? o_src2_q : dec_src2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_opcode <= '0;
      o_tgt    <= '0;
      o_wr_en  <= 1'b0;
      o_imm    <= '0;
      o_pc     <= '0;
      o_src1_q <= '0;
      o_src2_q <= '0;
    end else if (i_flush || (!i_hold && load_use)) begin
      o_valid  <= 1'b0;
      o_wr_en  <= 1'b0;
      o_src1_q <= '0;
      o_src2_q <= '0;
    end else if (!i_hold) begin
      o_valid  <= i_valid;
      o_opcode <= op;
      o_tgt    <= dec_tgt;
      o_wr_en  <= dec_wr_en;
      o_imm    <= dec_imm;
      o_pc     <= i_pc;
      o_src1_q <= dec_src1;
      o_src2_q <= dec_src2;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: combinational outputs checked each step,
// registered ID/EX contents checked one cycle later from a scoreboard queue.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_hold;
  logic [15:0] i_instr, i_pc;
  logic [2:0]  o_src1, o_src2, o_opcode, o_tgt, o_src1_q, o_src2_q;
  logic        o_stall, o_valid, o_wr_en;
  logic [15:0] o_imm, o_pc;

  id_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_pc(i_pc),
    .i_valid(i_valid), .i_flush(i_flush), .i_hold(i_hold),
    .o_src1(o_src1), .o_src2(o_src2), .o_stall(o_stall), .o_valid(o_valid),
    .o_opcode(o_opcode), .o_tgt(o_tgt), .o_wr_en(o_wr_en), .o_imm(o_imm),
    .o_pc(o_pc), .o_src1_q(o_src1_q), .o_src2_q(o_src2_q)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        valid;
    logic [2:0]  op;
    logic [2:0]  tgt;
    logic        wr;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [2:0]  s1;
    logic [2:0]  s2;
  } idex_t;

  typedef struct packed {
    idex_t e;
    logic  full;   // 0: bubble, only valid/wr/src_q are defined
  } sb_t;

  sb_t   sb_q[$];
  idex_t mdl;
  logic  mdl_full;
  int    checks = 0;
  int    errors = 0;

  function automatic idex_t dec(input logic [15:0] ins, input logic [15:0] pc, input logic v);
    idex_t r;
    logic [2:0] a, b, c;
    logic [15:0] s7;
    a = ins[12:10]; b = ins[9:7]; c = ins[2:0];
    s7 = {{9{ins[6]}}, ins[6:0]};
    r = '0;
    r.valid = v; r.op = ins[15:13]; r.pc = pc;
    case (ins[15:13])
      3'b000, 3'b010: begin r.s1 = b; r.s2 = c; r.tgt = a; r.wr = 1'b1; end
      3'b001, 3'b101: begin r.s1 = b; r.tgt = a; r.wr = 1'b1; r.imm = s7; end
      3'b011:         begin r.tgt = a; r.wr = 1'b1; r.imm = {ins[9:0], 6'b0}; end
      3'b100:         begin r.s1 = b; r.s2 = a; r.imm = s7; end
      3'b110:         begin r.s1 = a; r.s2 = b; r.imm = s7; end
      default:        begin r.s1 = b; r.tgt = a; r.wr = 1'b1; end
    endcase
    if (r.tgt == 3'd0) r.wr = 1'b0;
    if (!v) begin r.s1 = 3'd0; r.s2 = 3'd0; r.wr = 1'b0; end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg();
    sb_t x;
    if (sb_q.size() == 0) return;
    x = sb_q.pop_front();
    chk("o_valid",  {15'd0, o_valid},  {15'd0, x.e.valid});
    chk("o_wr_en",  {15'd0, o_wr_en},  {15'd0, x.e.wr});
    chk("o_src1_q", {13'd0, o_src1_q}, {13'd0, x.e.s1});
    chk("o_src2_q", {13'd0, o_src2_q}, {13'd0, x.e.s2});
    if (x.full) begin
      chk("o_opcode", {13'd0, o_opcode}, {13'd0, x.e.op});
      chk("o_tgt",    {13'd0, o_tgt},    {13'd0, x.e.tgt});
      chk("o_imm",    o_imm,             x.e.imm);
      chk("o_pc",     o_pc,              x.e.pc);
    end
  endtask

  // One clock of stimulus: check last cycle's ID/EX, drive, check comb, predict.
  task automatic step(input logic rst, input logic [15:0] ins, input logic [15:0] pc,
                      input logic v, input logic hold, input logic flush,
                      input logic [2:0] es1, input logic [2:0] es2, input logic estall);
    sb_t x;
    check_reg();
    i_rst = rst; i_instr = ins; i_pc = pc; i_valid = v; i_hold = hold; i_flush = flush;
    #1;
    chk("o_src1",  {13'd0, o_src1},  {13'd0, es1});
    chk("o_src2",  {13'd0, o_src2},  {13'd0, es2});
    chk("o_stall", {15'd0, o_stall}, {15'd0, estall});
    if (rst) begin
      mdl = '0; mdl_full = 1'b1;
    end else if (flush || (!hold && estall)) begin
      mdl.valid = 1'b0; mdl.wr = 1'b0; mdl.s1 = 3'd0; mdl.s2 = 3'd0; mdl_full = 1'b0;
    end else if (!hold) begin
      mdl = dec(ins, pc, v); mdl_full = 1'b1;
    end
    x.e = mdl; x.full = mdl_full;
    sb_q.push_back(x);
    @(posedge i_clk); #1;
  endtask

  initial begin
    mdl = '0; mdl_full = 1'b1;
    i_rst = 1'b1; i_instr = '0; i_pc = '0; i_valid = 1'b0; i_hold = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    //   rst   instr     pc        v     hold  flush src1  src2  stall
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    step(1'b0, 16'h0503, 16'h0010, 1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 1'b0); // ADD r1,r2,r3
    step(1'b0, 16'h257F, 16'h0011, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0); // ADDI r1,r2,-1
    step(1'b0, 16'h73FF, 16'h0012, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0); // LUI r4,0x3FF
    step(1'b0, 16'h9703, 16'h0013, 1'b1, 1'b0, 1'b0, 3'd6, 3'd5, 1'b0); // SW r5,r6,3
    step(1'b0, 16'hA505, 16'h0014, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0); // LW r1,r2,5
    step(1'b0, 16'h0C82, 16'h0015, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1); // load-use
    step(1'b0, 16'h0C82, 16'h0015, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b0); // re-presented
    step(1'b0, 16'hA100, 16'h0016, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0); // LW r0,r2,0
    step(1'b0, 16'h0C00, 16'h0017, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0); // no hazard on r0
    step(1'b0, 16'h0503, 16'h0018, 1'b1, 1'b0, 1'b0, 3'd2, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h257F, 16'h0019, 1'b1, 1'b1, 1'b0, 3'd2, 3'd3, 1'b1); // hold
    step(1'b0, 16'hA505, 16'h0019, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
    step(1'b0, 16'h0C82, 16'h001A, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0); // flush+hold+hazard
    step(1'b0, 16'h0C82, 16'h001B, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b0);
    step(1'b0, 16'hA505, 16'h001C, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
    step(1'b1, 16'h0C82, 16'h001D, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1); // reset mid-stall
    step(1'b0, 16'h0C82, 16'h001D, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b0);
    step(1'b0, 16'h0503, 16'h001E, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0); // invalid
    step(1'b0, 16'hE500, 16'h001F, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0); // JALR r1,r2
    step(1'b0, 16'hC57F, 16'h0020, 1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 1'b0); // BEQ r1,r2,-1
    step(1'b0, 16'h0000, 16'h0021, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    check_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
